// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
//   UART receiver that turns each valid serial byte into a one-cycle command
//   strobe with the byte split into control (high) and value (low) nibbles.
//   Frames are 8N1 by default. Defining UART_CMD_PARITY_EN switches the frame
//   to 8E1 and compiles in the PARITY state.
//
// Ports
//   sys_clk        in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   uart_rxd       in   asynchronous serial line, idle high, LSB first
//   command_flag   out  one-cycle strobe, nibbles valid in the same cycle
//   ctrl_command   out  received byte[7:4], held until the next good frame
//   value_command  out  received byte[3:0], held until the next good frame
//   frame_err      out  one-cycle strobe on stop-bit (or parity) error
//   rx_busy        out  high whenever the FSM is not in IDLE
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | half-bit wait, then confirm the start bit is still low
// DATA   | sampling the 8 data bits at mid-bit
// PARITY | sampling the even-parity bit (UART_CMD_PARITY_EN only)
// STOP   | sampling the stop bit, issuing command_flag or frame_err
// BREAK  | line held low after a bad stop bit, waiting for it to go high

module uart_cmd_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic       command_flag,
  output logic [3:0] ctrl_command,
  output logic [3:0] value_command,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
`ifdef UART_CMD_PARITY_EN
    ,
    S_PARITY = 3'd5
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        flag_q, flag_d;
  logic        ferr_q, ferr_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [3:0]  value_q, value_d;
  logic        par_err;

  logic rxd_sync;
  logic fall_edge;
  logic bit_tick;
  logic half_tick;

  assign rxd_sync  = rxd_s2_q;
  assign fall_edge = rxd_s3_q & ~rxd_s2_q;
  assign bit_tick  = (cnt_q == BIT_LAST);
  assign half_tick = (cnt_q == HALF_LAST);

`ifdef UART_CMD_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  // State register
  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fall_edge) state_d = S_START;
      S_START: if (half_tick) state_d = rxd_sync ? S_IDLE : S_DATA;
      S_DATA: begin
        if (bit_tick && bit_idx_q == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_CMD_PARITY_EN
      S_PARITY: if (bit_tick) state_d = S_STOP;
`endif
      S_STOP:  if (bit_tick) state_d = rxd_sync ? S_IDLE : S_BREAK;
      S_BREAK: if (rxd_sync) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d     = cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    flag_d    = 1'b0;
    ferr_d    = 1'b0;
    ctrl_d    = ctrl_q;
    value_d   = value_q;
`ifdef UART_CMD_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
`ifdef UART_CMD_PARITY_EN
        par_err_d = 1'b0;
`endif
      end
      S_START: if (half_tick) cnt_d = '0;
      S_DATA: begin
        if (bit_tick) begin
          cnt_d     = '0;
          shift_d   = {rxd_sync, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
`ifdef UART_CMD_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          cnt_d     = '0;
          // Even parity: data bits XOR parity bit must be zero.
          par_err_d = ^{shift_q, rxd_sync};
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (!rxd_sync || par_err) begin
            ferr_d = 1'b1;
          end else begin
            flag_d  = 1'b1;
            ctrl_d  = shift_q[7:4];
            value_d = shift_q[3:0];
          end
        end
      end
      S_BREAK: cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rxd_s1_q  <= 1'b1;
      rxd_s2_q  <= 1'b1;
      rxd_s3_q  <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      flag_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ctrl_q    <= '0;
      value_q   <= '0;
`ifdef UART_CMD_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      rxd_s1_q  <= uart_rxd;
      rxd_s2_q  <= rxd_s1_q;
      rxd_s3_q  <= rxd_s2_q;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      flag_q    <= flag_d;
      ferr_q    <= ferr_d;
      ctrl_q    <= ctrl_d;
      value_q   <= value_d;
`ifdef UART_CMD_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign command_flag  = flag_q;
  assign frame_err     = ferr_q;
  assign ctrl_command  = ctrl_q;
  assign value_command = value_q;
  assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed testbench for uart_cmd_rx at 50 MHz / 115200 baud (434 clocks per bit).

module tb_uart_cmd_rx;

  localparam int CPB = 434;
`ifdef UART_CMD_PARITY_EN
  localparam int EXP_LAT = 3 + 217 + 9 * CPB + CPB;
`else
  localparam int EXP_LAT = 3 + 217 + 9 * CPB;
`endif

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic       command_flag;
  logic [3:0] ctrl_command;
  logic [3:0] value_command;
  logic       frame_err;
  logic       rx_busy;

  uart_cmd_rx #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .uart_rxd     (uart_rxd),
    .command_flag (command_flag),
    .ctrl_command (ctrl_command),
    .value_command(value_command),
    .frame_err    (frame_err),
    .rx_busy      (rx_busy)
  );

  always #10 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_flag_cyc = 0;
  int flag_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int width_viol = 0;
  int nib_viol = 0;
  logic       flag_prev = 1'b0;
  logic       ferr_prev = 1'b0;
  logic       rst_prev = 1'b1;
  logic [7:0] nib_prev = 8'h00;
  logic [7:0] rx_q[$];
`ifdef UART_CMD_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always @(posedge sys_clk) cyc++;

  // Event monitor, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (command_flag) begin
      flag_cnt++;
      last_flag_cyc = cyc;
      rx_q.push_back({ctrl_command, value_command});
    end
    if (frame_err) ferr_cnt++;
    if (command_flag && frame_err) both_cnt++;
    if ((command_flag && flag_prev) || (frame_err && ferr_prev)) width_viol++;
    if ({ctrl_command, value_command} !== nib_prev && !command_flag && !rst && !rst_prev)
      nib_viol++;
    flag_prev = command_flag;
    ferr_prev = frame_err;
    rst_prev  = rst;
    nib_prev  = {ctrl_command, value_command};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    uart_rxd = b;
    wait_cyc(CPB);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_CMD_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_b);
  endtask

  int f0, e0, lat;

  initial begin
    rst = 1'b1;
    uart_rxd = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);

    // Reset state
    chk("rst_flag", command_flag, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_ctrl", ctrl_command, 0);
    chk("rst_value", value_command, 0);

    // Single byte 0x73
    f0 = flag_cnt; e0 = ferr_cnt;
    send_byte(8'h73, 1'b1);
    wait_cyc(2);
    chk("b73_flags", flag_cnt - f0, 1);
    chk("b73_ferr", ferr_cnt - e0, 0);
    chk("b73_ctrl", ctrl_command, 4'h7);
    chk("b73_value", value_command, 4'h3);
    lat = last_flag_cyc - start_cyc;
    chk("b73_latency", (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1) ? EXP_LAT : lat, EXP_LAT);

    // Start-bit glitch: 100 cycles low
    f0 = flag_cnt; e0 = ferr_cnt;
    uart_rxd = 1'b0;
    wait_cyc(50);
    chk("glitch_busy_hi", rx_busy, 1);
    wait_cyc(50);
    uart_rxd = 1'b1;
    for (int k = 0; k < 220 && rx_busy; k++) wait_cyc(1);
    chk("glitch_busy_lo", rx_busy, 0);
    wait_cyc(CPB);
    chk("glitch_flags", flag_cnt - f0, 0);
    chk("glitch_ferr", ferr_cnt - e0, 0);

    // Stop bit low, then line held low for 20 bit times
    f0 = flag_cnt; e0 = ferr_cnt;
    send_byte(8'h61, 1'b0);
    wait_cyc(20 * CPB);
    chk("brk_busy_hi", rx_busy, 1);
    chk("brk_ferr", ferr_cnt - e0, 1);
    chk("brk_flags", flag_cnt - f0, 0);
    chk("brk_ctrl", ctrl_command, 4'h7);
    chk("brk_value", value_command, 4'h3);
    uart_rxd = 1'b1;
    wait_cyc(6);
    chk("brk_busy_lo", rx_busy, 0);

    // Back-to-back frames, no idle gap
    rx_q.delete();
    f0 = flag_cnt; e0 = ferr_cnt;
    send_byte(8'h70, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h8F, 1'b1);
    wait_cyc(2);
    chk("b2b_count", rx_q.size(), 3);
    chk("b2b_ferr", ferr_cnt - e0, 0);
    if (rx_q.size() == 3) begin
      chk("b2b_0", rx_q[0], 8'h70);
      chk("b2b_1", rx_q[1], 8'h80);
      chk("b2b_2", rx_q[2], 8'h8F);
    end

    // Reset during bit 4 of 0x7F; the sender abandons that frame
    f0 = flag_cnt; e0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    uart_rxd = 1'b1;
    wait_cyc(217);
    chk("abort_busy_pre", rx_busy, 1);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("abort_busy", rx_busy, 0);
    chk("abort_ctrl", ctrl_command, 0);
    chk("abort_value", value_command, 0);
    wait_cyc(2 * CPB);
    chk("abort_flags", flag_cnt - f0, 0);
    chk("abort_ferr", ferr_cnt - e0, 0);
    send_byte(8'h60, 1'b1);
    wait_cyc(2);
    chk("post_rst_flags", flag_cnt - f0, 1);
    chk("post_rst_ctrl", ctrl_command, 4'h6);
    chk("post_rst_value", value_command, 4'h0);

`ifdef UART_CMD_PARITY_EN
    // Even parity good and bad
    f0 = flag_cnt; e0 = ferr_cnt;
    par_flip = 1'b0;
    send_byte(8'h71, 1'b1);
    wait_cyc(2);
    chk("par_ok_flags", flag_cnt - f0, 1);
    chk("par_ok_ctrl", ctrl_command, 4'h7);
    chk("par_ok_value", value_command, 4'h1);
    lat = last_flag_cyc - start_cyc;
    chk("par_latency", (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1) ? EXP_LAT : lat, EXP_LAT);
    f0 = flag_cnt; e0 = ferr_cnt;
    par_flip = 1'b1;
    send_byte(8'h71, 1'b1);
    wait_cyc(2);
    par_flip = 1'b0;
    chk("par_bad_flags", flag_cnt - f0, 0);
    chk("par_bad_ferr", ferr_cnt - e0, 1);
    chk("par_bad_busy", rx_busy, 0);
    chk("par_bad_ctrl", ctrl_command, 4'h7);
    chk("par_bad_value", value_command, 4'h1);
`endif

    // Whole-run invariants
    chk("flag_and_ferr", both_cnt, 0);
    chk("strobe_width", width_viol, 0);
    chk("nibble_hold", nib_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

UART command receiver that produces the byte-wide command stream consumed by the image-adjust path: `command_flag` plus the `ctrl_command` / `value_command` nibbles. It sits between the board RS-232 RX pin and the brightness/hue/greyscale control logic, in the `sys_clk` domain. It synchronises the asynchronous serial line, recovers 8N1 frames (optionally 8E1), and presents each valid byte as a one-cycle command strobe with a stable high/low nibble split.

## Interface
- `CLK_FREQ`, default 50_000_000: `sys_clk` frequency in Hz.
- `BAUD_RATE`, default 115200: serial bit rate.
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `uart_rxd`  in  1  asynchronous serial input; idle high, LSB first.
- `command_flag`  out  1  one-cycle strobe; the command nibbles are valid in the same cycle.
- `ctrl_command`  out  4  received byte[7:4]; holds its value until the next valid frame.
- `value_command`  out  4  received byte[3:0]; holds its value until the next valid frame.
- `frame_err`  out  1  one-cycle strobe on a stop-bit error (or parity error, when enabled).
- `rx_busy`  out  1  high whenever the state machine is not IDLE.

## Operation
- `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE`, truncated to an integer. `HALF_BIT = CLKS_PER_BIT / 2`.
- `uart_rxd` passes through a 2-FF synchroniser, then a third register for edge detection. The synchroniser resets to 1.
- Bit counter: 16-bit. Bit index: 3-bit. Shift register: 8-bit, with each new bit entering at the MSB and the register shifting right.
- States:
  - IDLE: on a falling edge of the synchronised line, clear the counter and go to START.
  - START: count to `HALF_BIT-1`, then sample. If the sample is 0, go to DATA. If it is 1 (a glitch), return to IDLE with no strobe.
  - DATA: sample every `CLKS_PER_BIT` cycles. After the 8th bit, go to PARITY (when enabled) or STOP.
  - PARITY: sample one bit and record a parity mismatch. Go to STOP.
  - STOP: sample one bit.
    - 1 with no parity error: load the nibbles, pulse `command_flag`, go to IDLE.
    - 0: pulse `frame_err` and go to BREAK.
    - 1 with a parity error: pulse `frame_err` only (nibbles unchanged) and go to IDLE.
  - BREAK: wait for the synchronised line to be 1, then go to IDLE. No strobes are issued in this state.
- All samples are taken at the mid-bit point. A new start edge is accepted on the first IDLE cycle, so back-to-back frames with zero idle gap are received.
- `command_flag` and `frame_err` are never high in the same cycle.
- Reset values: `command_flag`=0, `frame_err`=0, `rx_busy`=0, `ctrl_command`=0, `value_command`=0, state=IDLE.
- Reset asserted mid-frame aborts the frame immediately and produces no strobe. After release, the block waits for a fresh falling edge.

## Timing
- Pin-to-detect delay: 3 cycles (synchroniser plus edge register).
- `command_flag` asserts on the cycle after the stop-bit sample. That is 3 + HALF_BIT + 9·CLKS_PER_BIT cycles after the pin falls, ±1 cycle, plus CLKS_PER_BIT when parity is enabled.
- The strobe width is exactly 1 cycle, and the nibbles change only in that cycle.
- `rx_busy` rises one cycle after edge detection. It falls in the strobe cycle, or on the exit from BREAK.

## Configuration
- `UART_CMD_PARITY_EN` defined: the frame is 8E1, and the PARITY state is compiled in. A mismatch (XOR of the 8 data bits and the parity bit ≠ 0) produces `frame_err`, and no `command_flag`.
- Not defined: the frame is 8N1, the PARITY state and parity logic are absent, and STOP follows DATA directly.

## Test plan
All scenarios use CLK_FREQ=50 MHz and BAUD=115200, so CLKS_PER_BIT=434.
- Send byte 0x73 → a single `command_flag` pulse with `ctrl_command`=4'h7 and `value_command`=4'h3. Strobe lands 3+217+9·434 (±1) cycles after the start edge. `frame_err` stays 0.
- Drive the line low for 100 cycles, then high → no `command_flag`, no `frame_err`, and `rx_busy` returns to 0 within 220 cycles.
- Send 0x61 with the stop bit forced to 0, then hold the line low for 20 bit times before releasing → a single `frame_err` pulse, no `command_flag`, and `rx_busy` stays high until the line returns to 1. Nibbles remain at their previous value.
- Send 0x70, 0x80, 0x8F back-to-back with no idle gap → three flags in order with (7,0), (8,0), (8,F). Each is exactly 1 cycle wide.
- Assert `rst` for 1 cycle during bit 4 of 0x7F, then send 0x60 → no strobe for the aborted frame, then one flag with (6,0).
- With `UART_CMD_PARITY_EN`: 0x71 with correct even parity → flag with (7,1). The same byte with parity inverted → `frame_err` only.
